// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: N input channels in, one registered output stream out.
interface rr_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int S = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [S-1:0]   out_ch;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_mux.sv
// N-to-1 stream mux with fixed-select or round-robin arbitration and a single output register.
module rr_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic   clk,
  input logic   rst_n,
  rr_mux_if.slave bus
);
  localparam int S = $clog2(N);

  logic [S-1:0] ptr;
  logic [S-1:0] gnt;
  logic         gnt_vld;
  logic         load_en;
  logic         xfer;

  always_comb begin
    load_en = !bus.out_valid || bus.out_ready;
    gnt     = '0;
    gnt_vld = 1'b0;
    if (!bus.mode) begin
      // An out-of-range sel leaves nothing eligible.
      if (int'(bus.sel) < N) begin
        gnt     = bus.sel;
        gnt_vld = bus.in_valid[bus.sel];
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!gnt_vld && bus.in_valid[S'((int'(ptr) + k) % N)]) begin
          gnt     = S'((int'(ptr) + k) % N);
          gnt_vld = 1'b1;
        end
      end
    end
    xfer = gnt_vld && load_en && rst_n;
    bus.in_ready = '0;
    if (xfer) bus.in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (xfer) begin
      bus.out_data  <= bus.in_data[int'(gnt)*W +: W];
      bus.out_ch    <= gnt;
      bus.out_valid <= 1'b1;
      if (bus.mode) ptr <= (int'(gnt) == N-1) ? '0 : gnt + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: vector table for arbitration/throughput, hand sequences for backpressure, reset and N=3.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_mux_if #(.N(4), .W(8)) bus4 ();
  rr_mux_if #(.N(3), .W(8)) bus3 ();

  rr_mux #(.N(4), .W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_mux #(.N(3), .W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] oc;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // channel data: ch0=11 ch1=22 ch2=A5 ch3=44
    tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[5]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[8]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[9]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[10] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    tbl[11] = '{1'b1, 2'd0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[12] = '{1'b1, 2'd0, 4'b1100, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};

    rst_n = 1'b0;
    bus4.in_data = 32'h44A52211;
    bus4.in_valid = 4'b1111;
    bus4.mode = 1'b1;
    bus4.sel = 2'd0;
    bus4.out_ready = 1'b1;
    bus3.in_data = 24'h332211;
    bus3.in_valid = 3'b000;
    bus3.mode = 1'b0;
    bus3.sel = 2'd0;
    bus3.out_ready = 1'b1;

    tick;
    tick;
    chk("reset in_ready", 64'(bus4.in_ready), 64'h0);
    chk("reset out_valid", 64'(bus4.out_valid), 64'h0);
    chk("reset out_data", 64'(bus4.out_data), 64'h0);
    chk("reset out_ch", 64'(bus4.out_ch), 64'h0);
    chk("reset n3 out_valid", 64'(bus3.out_valid), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus4.mode = tbl[i].mode;
      bus4.sel = tbl[i].sel;
      bus4.in_valid = tbl[i].iv;
      bus4.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(bus4.in_ready), 64'(tbl[i].rdy));
      tick;
      chk($sformatf("v%0d out_valid", i), 64'(bus4.out_valid), 64'(tbl[i].ov));
      chk($sformatf("v%0d out_data", i), 64'(bus4.out_data), 64'(tbl[i].od));
      chk($sformatf("v%0d out_ch", i), 64'(bus4.out_ch), 64'(tbl[i].oc));
    end

    // backpressure: ptr=0, output empty
    bus4.mode = 1'b1;
    bus4.in_valid = 4'b1111;
    bus4.out_ready = 1'b1;
    tick;
    chk("bp load out_data", 64'(bus4.out_data), 64'h11);
    bus4.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d in_ready", c), 64'(bus4.in_ready), 64'h0);
      tick;
      chk($sformatf("bp%0d out_valid", c), 64'(bus4.out_valid), 64'h1);
      chk($sformatf("bp%0d out_data", c), 64'(bus4.out_data), 64'h11);
      chk($sformatf("bp%0d out_ch", c), 64'(bus4.out_ch), 64'h0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 64'(bus4.in_ready), 64'b0010);
    tick;
    chk("bp release out_valid", 64'(bus4.out_valid), 64'h1);
    chk("bp release out_data", 64'(bus4.out_data), 64'h22);
    chk("bp release out_ch", 64'(bus4.out_ch), 64'h1);

    // reset mid-stream: word 22 held, ptr=2
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(bus4.in_ready), 64'h0);
    tick;
    chk("midrst out_valid", 64'(bus4.out_valid), 64'h0);
    chk("midrst out_data", 64'(bus4.out_data), 64'h0);
    chk("midrst out_ch", 64'(bus4.out_ch), 64'h0);
    rst_n = 1'b1;
    bus4.in_valid = 4'b0110;
    #1;
    chk("postrst in_ready", 64'(bus4.in_ready), 64'b0010);
    tick;
    chk("postrst out_valid", 64'(bus4.out_valid), 64'h1);
    chk("postrst out_data", 64'(bus4.out_data), 64'h22);
    chk("postrst out_ch", 64'(bus4.out_ch), 64'h1);
    bus4.in_valid = 4'b0000;

    // N=3 with sel beyond the last channel
    bus3.mode = 1'b0;
    bus3.sel = 2'd3;
    bus3.in_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("oor%0d in_ready", c), 64'(bus3.in_ready), 64'h0);
      tick;
      chk($sformatf("oor%0d out_valid", c), 64'(bus3.out_valid), 64'h0);
    end
    bus3.sel = 2'd2;
    #1;
    chk("n3 sel2 in_ready", 64'(bus3.in_ready), 64'b100);
    tick;
    chk("n3 sel2 out_valid", 64'(bus3.out_valid), 64'h1);
    chk("n3 sel2 out_data", 64'(bus3.out_data), 64'h33);
    chk("n3 sel2 out_ch", 64'(bus3.out_ch), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
